// File: rtl/neighbor_table_ctrl_if.sv
// Requester-side bundle of the neighbor table controller:
// the write request handshake and the scan stream handshake.
interface neighbor_table_ctrl_if #(
    parameter int IDX_W      = 5,
    parameter int WORD_WIDTH = 16
);
    logic                  wr_req;
    logic [WORD_WIDTH-1:0] wr_node_id;
    logic                  wr_ack;
    logic                  drop_pulse;
    logic                  scan_start;
    logic                  scan_valid;
    logic                  scan_ready;
    logic [IDX_W-1:0]      scan_idx;
    logic                  scan_busy;
    logic                  scan_done;

    modport master (
        output wr_req, wr_node_id, scan_start, scan_ready,
        input  wr_ack, drop_pulse, scan_valid, scan_idx,
        input  scan_busy, scan_done
    );

    modport slave (
        input  wr_req, wr_node_id, scan_start, scan_ready,
        output wr_ack, drop_pulse, scan_valid, scan_idx,
        output scan_busy, scan_done
    );
endinterface

// File: rtl/neighbor_table_ctrl.sv
// Neighbor table index-port controller: write/scan arbitration,
// shadow slot allocation and heartbeat clear. Option: NBR_TBL_AGE_EN.
module neighbor_table_ctrl #(
    parameter int                    NUM_ENTRIES = 32,
    parameter int                    IDX_W       = 5,
    parameter int                    WORD_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] MY_NODE_ID  = 16'h000C
) (
    input  logic                 clk,
    input  logic                 rst,
    neighbor_table_ctrl_if.slave bus,
    input  logic                 hb_reset,
    output logic                 tbl_wr_en,
    output logic [IDX_W-1:0]     tbl_idx,
    output logic                 tbl_hb_reset,
    output logic [IDX_W:0]       entry_count,
    output logic                 table_full
);
    localparam int PW = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_COMMIT, S_SCAN, S_CLEAR
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [WORD_WIDTH-1:0] shadow_q [NUM_ENTRIES];
    logic [PW-1:0]         ptr_q;
    logic                  scan_act_q;
    logic                  pend_q;
    logic                  hb_pend_q;
    logic [IDX_W-1:0]      slot_q;
    logic                  hit_q;
    logic                  full_q;
    logic [PW-1:0]         count_q;
`ifdef NBR_TBL_AGE_EN
    logic [NUM_ENTRIES-1:0] seen_q;
    logic [PW-1:0]         surv_cnt;
`endif

    logic                  lk_hit, lk_free;
    logic [IDX_W-1:0]      lk_hit_idx, lk_free_idx;
    logic                  sc_found;
    logic [IDX_W-1:0]      sc_idx;
    logic                  is_mine, wr_drop, wr_store;
    logic                  ret_scan, hb_due;

    assign entry_count   = count_q;
    assign table_full    = (count_q == PW'(NUM_ENTRIES));
    assign bus.scan_busy = scan_act_q;

    assign is_mine  = (bus.wr_node_id == MY_NODE_ID);
    assign wr_drop  = !is_mine && full_q && !hit_q;
    assign wr_store = !is_mine && !wr_drop;
    assign ret_scan = scan_act_q || pend_q;
    assign hb_due   = hb_pend_q || hb_reset;

    // Slot lookup: matching entry first, else lowest free slot
    always_comb begin
        lk_hit      = 1'b0;
        lk_free     = 1'b0;
        lk_hit_idx  = '0;
        lk_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && shadow_q[i] == bus.wr_node_id) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                lk_free     = 1'b1;
                lk_free_idx = IDX_W'(i);
            end
        end
    end

    // Lowest valid entry at or above the scan pointer
    always_comb begin
        sc_found = 1'b0;
        sc_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && PW'(i) >= ptr_q) begin
                sc_found = 1'b1;
                sc_idx   = IDX_W'(i);
            end
        end
    end

`ifdef NBR_TBL_AGE_EN
    // Number of entries that survive an aging clear
    always_comb begin
        surv_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            surv_cnt = surv_cnt + PW'(valid_q[i] & seen_q[i]);
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: clear beats write beats scan; writes never split
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (hb_reset)            state_d = S_CLEAR;
                else if (bus.wr_req)     state_d = S_WRITE;
                else if (bus.scan_start) state_d = S_SCAN;
            end
            S_WRITE: begin
                if (wr_store)      state_d = S_COMMIT;
                else if (hb_due)   state_d = S_CLEAR;
                else if (ret_scan) state_d = S_SCAN;
                else               state_d = S_IDLE;
            end
            S_COMMIT: begin
                if (hb_due)        state_d = S_CLEAR;
                else if (ret_scan) state_d = S_SCAN;
                else               state_d = S_IDLE;
            end
            S_SCAN: begin
                if (hb_reset)
                    state_d = S_CLEAR;
                else if (bus.wr_req && (!sc_found || bus.scan_ready))
                    state_d = S_WRITE;
                else if (!sc_found)
                    state_d = S_IDLE;
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bus.wr_ack     = 1'b0;
        bus.drop_pulse = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_idx   = '0;
        bus.scan_done  = 1'b0;
        tbl_wr_en      = 1'b0;
        tbl_idx        = '0;
        tbl_hb_reset   = 1'b0;
        unique case (state_q)
            S_WRITE: begin
                bus.wr_ack     = 1'b1;
                bus.drop_pulse = wr_drop;
                tbl_wr_en      = wr_store;
                if (wr_store) tbl_idx = slot_q;
            end
            S_COMMIT: tbl_idx = slot_q;
            S_SCAN: begin
                bus.scan_valid = sc_found;
                bus.scan_idx   = sc_idx;
                tbl_idx        = sc_idx;
                bus.scan_done  = !sc_found && !hb_reset && !bus.wr_req;
            end
            S_CLEAR: begin
`ifdef NBR_TBL_AGE_EN
                tbl_hb_reset = 1'b0;
`else
                tbl_hb_reset = 1'b1;
`endif
                bus.scan_done = scan_act_q;
            end
            default: ;
        endcase
    end

    // Shadow table, scan bookkeeping and pending flags
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            ptr_q      <= '0;
            scan_act_q <= 1'b0;
            pend_q     <= 1'b0;
            hb_pend_q  <= 1'b0;
            slot_q     <= '0;
            hit_q      <= 1'b0;
            full_q     <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) shadow_q[i] <= '0;
`ifdef NBR_TBL_AGE_EN
            seen_q     <= '0;
`endif
        end else begin
            if (state_d == S_WRITE) begin
                slot_q <= lk_hit ? lk_hit_idx : lk_free_idx;
                hit_q  <= lk_hit;
                full_q <= !lk_hit && !lk_free;
            end
            if (state_q == S_IDLE && !hb_reset && bus.wr_req && bus.scan_start)
                pend_q <= 1'b1;
            if ((state_q == S_WRITE || state_q == S_COMMIT) && hb_reset)
                hb_pend_q <= 1'b1;
            if (state_q == S_WRITE && wr_store) begin
                valid_q[slot_q]  <= 1'b1;
                shadow_q[slot_q] <= bus.wr_node_id;
`ifdef NBR_TBL_AGE_EN
                seen_q[slot_q]   <= 1'b1;
`endif
                if (!hit_q && count_q != PW'(NUM_ENTRIES))
                    count_q <= count_q + PW'(1);
            end
            if (state_q == S_SCAN && sc_found && bus.scan_ready && !hb_reset)
                ptr_q <= {1'b0, sc_idx} + PW'(1);
            if (state_d == S_SCAN && !scan_act_q) begin
                scan_act_q <= 1'b1;
                ptr_q      <= '0;
                pend_q     <= 1'b0;
            end
            if (state_q == S_SCAN && state_d == S_IDLE)
                scan_act_q <= 1'b0;
            if (state_q == S_CLEAR) begin
`ifdef NBR_TBL_AGE_EN
                valid_q <= valid_q & seen_q;
                seen_q  <= '0;
                count_q <= surv_cnt;
`else
                valid_q <= '0;
                count_q <= '0;
`endif
                scan_act_q <= 1'b0;
                pend_q     <= 1'b0;
                hb_pend_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// Self-checking bench for neighbor_table_ctrl: directed steps
// plus a randomized phase against a slot-array reference model.
module tb_neighbor_table_ctrl;
    localparam logic [15:0] MY_ID = 16'h000C;

    logic       clk = 1'b0;
    logic       rst;
    logic       hb_reset;
    logic       tbl_wr_en;
    logic [4:0] tbl_idx;
    logic       tbl_hb_reset;
    logic [5:0] entry_count;
    logic       table_full;

    int total = 0;
    int bad   = 0;

    bit          m_vld [32];
    logic [15:0] m_id  [32];
    int          m_cnt;

    neighbor_table_ctrl_if bus ();

    neighbor_table_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .hb_reset     (hb_reset),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_idx      (tbl_idx),
        .tbl_hb_reset (tbl_hb_reset),
        .entry_count  (entry_count),
        .table_full   (table_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
        m_cnt = 0;
    endtask

    task automatic do_write(input logic [15:0] id);
        int  slot;
        int  n;
        bit  hit;
        bit  mine;
        bit  drop;
        mine = (id == MY_ID);
        hit  = 1'b0;
        slot = -1;
        for (int i = 0; i < 32; i++)
            if (!hit && m_vld[i] && m_id[i] == id) begin
                hit  = 1'b1;
                slot = i;
            end
        if (!hit)
            for (int i = 31; i >= 0; i--)
                if (!m_vld[i]) slot = i;
        drop = !mine && slot < 0;
        bus.wr_req     = 1'b1;
        bus.wr_node_id = id;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (bus.wr_ack) break;
        end
        chk("wr_ack", bus.wr_ack, 1);
        chk("wr_drop", bus.drop_pulse, drop);
        chk("wr_en", tbl_wr_en, !mine && !drop);
        if (!mine && !drop) chk("wr_idx", tbl_idx, slot);
        bus.wr_req = 1'b0;
        if (!mine && !drop) begin
            @(negedge clk);
            chk("commit_idx", tbl_idx, slot);
            chk("commit_no_wr", tbl_wr_en, 0);
            if (!hit) m_cnt++;
            m_vld[slot] = 1'b1;
            m_id[slot]  = id;
        end
        @(negedge clk);
        chk("wr_count", entry_count, m_cnt);
        chk("wr_full", table_full, m_cnt == 32);
    endtask

    task automatic do_hb();
        hb_reset = 1'b1;
        @(negedge clk);
        chk("hb_strobe", tbl_hb_reset, 1);
        chk("hb_no_done", bus.scan_done, 0);
        hb_reset = 1'b0;
        @(negedge clk);
        model_clear();
        chk("hb_count", entry_count, 0);
        chk("hb_full", table_full, 0);
    endtask

    task automatic do_scan();
        int exp_q [$];
        int k;
        int n;
        bit r;
        bit done;
        for (int i = 0; i < 32; i++) if (m_vld[i]) exp_q.push_back(i);
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        k = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            n++;
            r = 1'b0;
            if (bus.scan_done) begin
                done = 1'b1;
                chk("scan_len", k, exp_q.size());
                chk("scan_done_valid", bus.scan_valid, 0);
            end else begin
                if (bus.scan_valid) begin
                    chk("scan_idx", bus.scan_idx,
                        (k < exp_q.size()) ? exp_q[k] : 99);
                    r = 1'($urandom_range(0, 1));
                    if (r) k++;
                end
                bus.scan_ready = r;
                @(negedge clk);
            end
        end
        if (!done) chk("scan_timeout", 0, 1);
        bus.scan_ready = 1'b0;
        @(negedge clk);
        chk("scan_busy_end", bus.scan_busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        hb_reset       = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_node_id = '0;
        bus.scan_start = 1'b0;
        bus.scan_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", bus.wr_ack, 0);
        chk("rst_busy", bus.scan_busy, 0);
        chk("rst_valid", bus.scan_valid, 0);
        chk("rst_wr_en", tbl_wr_en, 0);
        chk("rst_idx", tbl_idx, 0);
        chk("rst_count", entry_count, 0);
        chk("rst_full", table_full, 0);

        do_write(16'h0001);
        do_write(16'h0002);
        do_write(16'h0002);
        do_write(MY_ID);

        do_hb();
        for (int i = 0; i < 32; i++) do_write(16'h0100 + 16'(i));
        do_write(16'h0099);
        do_write(16'h0105);
        do_scan();

        do_hb();
        do_scan();

        for (int i = 1; i <= 4; i++) do_write(16'h0A00 + 16'(i));
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        chk("pre_v0", bus.scan_valid, 1);
        chk("pre_i0", bus.scan_idx, 0);
        bus.scan_ready = 1'b1;
        @(negedge clk);
        chk("pre_i1", bus.scan_idx, 1);
        bus.scan_ready = 1'b0;
        bus.wr_req     = 1'b1;
        bus.wr_node_id = 16'h0050;
        @(negedge clk);
        chk("pre_hold_i1", bus.scan_idx, 1);
        chk("pre_no_ack", bus.wr_ack, 0);
        bus.scan_ready = 1'b1;
        @(negedge clk);
        chk("pre_ack", bus.wr_ack, 1);
        chk("pre_wr_en", tbl_wr_en, 1);
        chk("pre_wr_idx", tbl_idx, 4);
        chk("pre_busy", bus.scan_busy, 1);
        bus.wr_req     = 1'b0;
        bus.scan_ready = 1'b0;
        @(negedge clk);
        chk("pre_commit_idx", tbl_idx, 4);
        m_vld[4] = 1'b1;
        m_id[4]  = 16'h0050;
        m_cnt++;
        bus.scan_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("pre_resume_idx", bus.scan_idx, k);
        end
        @(negedge clk);
        chk("pre_done", bus.scan_done, 1);
        bus.scan_ready = 1'b0;
        @(negedge clk);
        chk("pre_busy_end", bus.scan_busy, 0);
        chk("pre_count", entry_count, m_cnt);

        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        chk("hbs_i0", bus.scan_idx, 0);
        hb_reset = 1'b1;
        @(negedge clk);
        chk("hbs_strobe", tbl_hb_reset, 1);
        chk("hbs_done", bus.scan_done, 1);
        hb_reset = 1'b0;
        @(negedge clk);
        model_clear();
        chk("hbs_count", entry_count, 0);
        chk("hbs_busy", bus.scan_busy, 0);

        do_write(16'h0601);
        do_write(16'h0602);
        bus.wr_req     = 1'b1;
        bus.wr_node_id = 16'h0603;
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        chk("pend_ack", bus.wr_ack, 1);
        chk("pend_wr_idx", tbl_idx, 2);
        bus.wr_req = 1'b0;
        @(negedge clk);
        chk("pend_commit_idx", tbl_idx, 2);
        m_vld[2] = 1'b1;
        m_id[2]  = 16'h0603;
        m_cnt++;
        bus.scan_ready = 1'b1;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            chk("pend_scan_idx", bus.scan_idx, k);
        end
        @(negedge clk);
        chk("pend_done", bus.scan_done, 1);
        bus.scan_ready = 1'b0;
        @(negedge clk);

        for (int it = 0; it < 250; it++) begin
            int op;
            op = int'($urandom_range(0, 99));
            if (op < 78) do_write(16'($urandom_range(1, 40)));
            else if (op < 96) do_scan();
            else do_hb();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
